vmem_arbiter: RTL and testbench

Three-port arbiter sharing the single-port synchronous video RAM between display scanout, the CPU and the DMA engine. Sits between the RAM and the display's `vmem_*` port, the CPU's video-memory bus and the DMA master. Display always has priority; because display issues at most one access per two cycles, CPU and DMA always receive the interleaved slots, round-robin between them. Scanout timing is never disturbed by CPU or DMA traffic.

---
 rtl/vmem_arbiter_if.sv | 67 ++++++
 rtl/vmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_vmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vmem_arbiter_if
//  Description : Bundle of the display, CPU, DMA and RAM-side signals that
//                meet at the video-memory arbiter.
//                slave  - arbiter view.
//                master - requesters plus RAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface vmem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // display scanout port (read only)
  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ready;
  logic [DATA_W-1:0] disp_rdata;

  // CPU video-memory bus
  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [STRB_W-1:0] cpu_wstrb;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  // DMA master
  logic              dma_valid;
  logic [ADDR_W-1:0] dma_addr;
  logic [STRB_W-1:0] dma_wstrb;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_rdata;

  // single-port synchronous RAM
  logic              ram_en;
  logic [STRB_W-1:0] ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_valid, disp_addr,
    output disp_ready, disp_rdata,
    input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    output cpu_ready, cpu_rdata,
    input  dma_valid, dma_addr, dma_wstrb, dma_wdata,
    output dma_ready, dma_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output disp_valid, disp_addr,
    input  disp_ready, disp_rdata,
    output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    output dma_valid, dma_addr, dma_wstrb, dma_wdata,
    input  dma_ready, dma_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/vmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vmem_arbiter
//  Description : Shares one single-port synchronous video RAM between display
//                scanout, the CPU and the DMA engine. Display has absolute
//                priority. CPU and DMA round-robin over the remaining slots.
//                A grant in cycle N completes with a one-cycle ready in N+1.
//  Revision    : 1.0  initial release
// ============================================================================
module vmem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  vmem_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  // Who owns the RAM access issued in the previous cycle; doubles as the
  // response-stage state since the owner gets its ready this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  // Round-robin pointer between the two low-priority requesters.
  typedef enum logic {
    PTR_CPU = 1'b0,
    PTR_DMA = 1'b1
  } ptr_t;

  owner_t            owner_q;
  owner_t            grant;
  ptr_t              ptr_q;
  ptr_t              ptr_d;
  logic              run_q;

  logic              disp_elig;
  logic              cpu_elig;
  logic              dma_elig;

  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic [STRB_W-1:0] grant_we;

  // Grants are held off until the first clock edge after rst_n rises, so
  // the release is synchronous even though the assertion is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // A requester whose access is completing this cycle still shows valid
  // with the old address, so it must sit this slot out.
  assign disp_elig = run_q && bus.disp_valid && (owner_q != OWN_DISP);
  assign cpu_elig  = run_q && bus.cpu_valid  && (owner_q != OWN_CPU);
  assign dma_elig  = run_q && bus.dma_valid  && (owner_q != OWN_DMA);

  // Issue stage: display first, then the pointer breaks CPU/DMA ties.
  always_comb begin
    grant = OWN_NONE;
    if (disp_elig) begin
      grant = OWN_DISP;
    end else if (cpu_elig && dma_elig) begin
      grant = (ptr_q == PTR_CPU) ? OWN_CPU : OWN_DMA;
    end else if (cpu_elig) begin
      grant = OWN_CPU;
    end else if (dma_elig) begin
      grant = OWN_DMA;
    end
  end

  // Steer the winner's address, data and strobes onto the RAM port.
  always_comb begin
    grant_addr  = '0;
    grant_wdata = '0;
    grant_we    = '0;
    case (grant)
      OWN_DISP: begin
        grant_addr  = bus.disp_addr;
      end
      OWN_CPU: begin
        grant_addr  = bus.cpu_addr;
        grant_wdata = bus.cpu_wdata;
        grant_we    = bus.cpu_wstrb;
      end
      OWN_DMA: begin
        grant_addr  = bus.dma_addr;
        grant_wdata = bus.dma_wdata;
        grant_we    = bus.dma_wstrb;
      end
      default: begin
        grant_addr  = '0;
      end
    endcase
  end

  assign bus.ram_en    = (grant != OWN_NONE);
  assign bus.ram_we    = grant_we;
  assign bus.ram_addr  = grant_addr;
  assign bus.ram_wdata = grant_wdata;

  // Pointer hands the next tie to whichever of CPU/DMA was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (grant == OWN_CPU) begin
      ptr_d = PTR_DMA;
    end else if (grant == OWN_DMA) begin
      ptr_d = PTR_CPU;
    end
  end

  // Owner and pointer registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      ptr_q   <= PTR_CPU;
    end else begin
      owner_q <= grant;
      ptr_q   <= ptr_d;
    end
  end

  // Response stage: RAM data arrives one cycle after the grant, exactly
  // when the registered owner gets its ready pulse.
  assign bus.disp_ready = (owner_q == OWN_DISP);
  assign bus.cpu_ready  = (owner_q == OWN_CPU);
  assign bus.dma_ready  = (owner_q == OWN_DMA);

  assign bus.disp_rdata = bus.ram_rdata;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = bus.ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmem_arbiter
//  Description : Directed bench for vmem_arbiter with a behavioural RAM,
//                simple hold-until-ready requesters and a per-port scoreboard
//                of expected read data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vmem_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int MEM_N  = 4096;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              is_read;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  vmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DATA_W-1:0] init_word(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    return {lo ^ 16'h5A5A, ~lo};
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [STRB_W-1:0] st);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < STRB_W; b++) begin
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // behavioural single-port synchronous RAM, read data one cycle later
  logic [DATA_W-1:0] ram [0:MEM_N-1];
  logic [DATA_W-1:0] ram_q;
  logic [11:0]       ram_idx;
  assign ram_idx = bus.ram_addr[11:0];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_N; i++) ram[i] <= init_word(i);
    end else if (bus.ram_en) begin
      ram_q        <= ram[ram_idx];
      ram[ram_idx] <= merge(ram[ram_idx], bus.ram_wdata, bus.ram_we);
    end
  end
  assign bus.ram_rdata = ram_q;

  // bench state
  logic [DATA_W-1:0] shadow [0:MEM_N-1];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  req_t rq_d[$], rq_c[$], rq_m[$];
  exp_t eq_d[$], eq_c[$], eq_m[$];
  logic [2:0] busy, done;
  int   load_cyc [3];
  string nm [3] = '{"disp", "cpu", "dma"};

  logic              s_en;
  logic [STRB_W-1:0] s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [2:0]        s_rdy;
  logic [DATA_W-1:0] s_cpu_rd;
  int                s_cpu_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // put a request on a port and record what its completion must return
  task automatic launch(input int p, input req_t r);
    exp_t e;
    int   idx;
    idx = int'(r.addr[11:0]);
    if (r.wstrb == '0) begin
      e.is_read = 1'b1;
      e.data    = shadow[idx];
    end else begin
      shadow[idx] = merge(shadow[idx], r.wdata, r.wstrb);
      e.is_read = 1'b0;
      e.data    = shadow[idx];
    end
    case (p)
      0: begin eq_d.push_back(e); bus.disp_valid = 1'b1; bus.disp_addr = r.addr; end
      1: begin eq_c.push_back(e); bus.cpu_valid = 1'b1; bus.cpu_addr = r.addr;
               bus.cpu_wstrb = r.wstrb; bus.cpu_wdata = r.wdata; end
      default: begin eq_m.push_back(e); bus.dma_valid = 1'b1; bus.dma_addr = r.addr;
               bus.dma_wstrb = r.wstrb; bus.dma_wdata = r.wdata; end
    endcase
    busy[p] = 1'b1;
    load_cyc[p] = cyc_n;
  endtask

  task automatic retire(input int p);
    case (p)
      0: bus.disp_valid = 1'b0;
      1: bus.cpu_valid  = 1'b0;
      default: bus.dma_valid = 1'b0;
    endcase
  endtask

  task automatic service();
    req_t r;
    for (int p = 0; p < 3; p++) begin
      if (done[p]) begin
        done[p] = 1'b0;
        busy[p] = 1'b0;
        retire(p);
      end
    end
    if (!busy[0] && rq_d.size() > 0) begin r = rq_d.pop_front(); launch(0, r); end
    if (!busy[1] && rq_c.size() > 0) begin r = rq_c.pop_front(); launch(1, r); end
    if (!busy[2] && rq_m.size() > 0) begin r = rq_m.pop_front(); launch(2, r); end
  endtask

  // pop the scoreboard for a port that just showed ready
  task automatic complete(input int p, input logic [DATA_W-1:0] rd);
    exp_t e;
    int   sz;
    case (p)
      0: sz = eq_d.size();
      1: sz = eq_c.size();
      default: sz = eq_m.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("%s_unexpected_ready", nm[p]), 64'(sz), 64'd1);
    end else begin
      case (p)
        0: e = eq_d.pop_front();
        1: e = eq_c.pop_front();
        default: e = eq_m.pop_front();
      endcase
      if (e.is_read) chk($sformatf("%s_rdata", nm[p]), 64'(rd), 64'(e.data));
      done[p] = 1'b1;
    end
  endtask

  // sample at the falling edge, then move requesters just after the rise
  task automatic cyc();
    @(negedge clk);
    s_en       = bus.ram_en;
    s_we       = bus.ram_we;
    s_addr     = bus.ram_addr;
    s_rdy      = {bus.dma_ready, bus.cpu_ready, bus.disp_ready};
    s_cpu_rd   = bus.cpu_rdata;
    s_cpu_wait = (cyc_n - 1) - load_cyc[1];
    if (s_rdy[0]) complete(0, bus.disp_rdata);
    if (s_rdy[1]) complete(1, bus.cpu_rdata);
    if (s_rdy[2]) complete(2, bus.dma_rdata);
    @(posedge clk);
    #1;
    cyc_n++;
    service();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic [DATA_W-1:0] iw;
    int last_x;
    int cur;
    int guard;

    for (int i = 0; i < MEM_N; i++) shadow[i] = init_word(i);
    busy = '0;
    done = '0;
    for (int p = 0; p < 3; p++) load_cyc[p] = 0;
    bus.disp_valid = 1'b0; bus.disp_addr = '0;
    bus.cpu_valid  = 1'b0; bus.cpu_addr  = '0; bus.cpu_wstrb = '0; bus.cpu_wdata = '0;
    bus.dma_valid  = 1'b0; bus.dma_addr  = '0; bus.dma_wstrb = '0; bus.dma_wdata = '0;

    @(posedge clk);
    #1;
    mem_init = 1'b0;

    // reset with everyone requesting
    r = '{addr: 17'h00020, wstrb: '0, wdata: '0}; rq_d.push_back(r);
    r = '{addr: 17'h00030, wstrb: '0, wdata: '0}; rq_c.push_back(r);
    r = '{addr: 17'h00040, wstrb: '0, wdata: '0}; rq_m.push_back(r);
    service();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_ram_en", 64'(s_en), 64'd0);
      chk("rst_ready", 64'(s_rdy), 64'd0);
    end
    rst_n = 1'b1;
    cyc();
    chk("release_cycle_en", 64'(s_en), 64'd0);
    cyc();
    chk("first_grant_en", 64'(s_en), 64'd1);
    chk("first_grant_disp_addr", 64'(s_addr), 64'h20);
    chk("first_grant_we", 64'(s_we), 64'd0);
    cyc();
    chk("second_ready_disp", 64'(s_rdy), 64'b001);
    chk("second_grant_cpu_addr", 64'(s_addr), 64'h30);
    cyc();
    chk("third_ready_cpu", 64'(s_rdy), 64'b010);
    chk("third_grant_dma_addr", 64'(s_addr), 64'h40);
    cyc();
    chk("fourth_ready_dma", 64'(s_rdy), 64'b100);
    chk("fourth_idle_en", 64'(s_en), 64'd0);

    // display-only continuous reads
    r = '{addr: 17'h00400, wstrb: '0, wdata: '0}; rq_d.push_back(r);
    r = '{addr: 17'h00401, wstrb: '0, wdata: '0}; rq_d.push_back(r);
    service();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("disp_en_alternate", 64'(s_en), 64'(i % 2 == 0));
      chk("disp_ready_alternate", 64'(s_rdy[0]), 64'(i % 2 == 1));
      if (i % 2 == 0) chk("disp_addr", 64'(s_addr), 64'(17'h00400 + 17'(i / 2)));
    end

    // CPU partial write then readback
    r = '{addr: 17'h00010, wstrb: 4'b0011, wdata: 32'hDEADBEEF}; rq_c.push_back(r);
    r = '{addr: 17'h00010, wstrb: '0, wdata: '0}; rq_c.push_back(r);
    service();
    cyc();
    chk("cpu_write_we", 64'(s_we), 64'b0011);
    chk("cpu_write_addr", 64'(s_addr), 64'h10);
    cyc();
    chk("cpu_write_ready", 64'(s_rdy), 64'b010);
    chk("cpu_inflight_no_grant", 64'(s_en), 64'd0);
    cyc();
    chk("cpu_read_en", 64'(s_en), 64'd1);
    chk("cpu_read_we", 64'(s_we), 64'd0);
    cyc();
    chk("cpu_read_ready", 64'(s_rdy), 64'b010);
    iw = init_word(16);
    chk("cpu_rmw_read", 64'(s_cpu_rd), 64'({iw[31:16], 16'hBEEF}));

    // all three saturating for 40 cycles
    for (int i = 0; i < 20; i++) begin
      r = '{addr: 17'(32'h500 + i), wstrb: '0, wdata: '0}; rq_d.push_back(r);
    end
    for (int i = 0; i < 10; i++) begin
      r = '{addr: 17'(32'h100 + i), wstrb: '0, wdata: '0}; rq_c.push_back(r);
      if (i % 2 == 0) r = '{addr: 17'(32'h300 + i / 2), wstrb: 4'hF, wdata: 32'hCAFE0000 ^ i};
      else            r = '{addr: 17'(32'h300 + i / 2), wstrb: '0, wdata: '0};
      rq_m.push_back(r);
    end
    service();
    last_x = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("sat_ram_en", 64'(s_en), 64'd1);
      if (i >= 1) begin
        chk("sat_disp_every2", 64'(s_rdy[0]), 64'(i % 2 == 1));
        chk("sat_one_ready", 64'($countones(s_rdy)), 64'd1);
      end
      if (s_rdy[1] || s_rdy[2]) begin
        cur = s_rdy[1] ? 1 : 2;
        if (last_x != 0) chk("sat_cpu_dma_alternate", 64'(cur != last_x), 64'd1);
        last_x = cur;
      end
      if (s_rdy[1]) chk("sat_cpu_wait_le4", 64'(s_cpu_wait <= 4), 64'd1);
    end
    guard = 0;
    while ((busy != '0 || rq_d.size() + rq_c.size() + rq_m.size() > 0) && guard < 20) begin
      cyc();
      guard++;
    end
    chk("sat_drain_in_time", 64'(guard < 20), 64'd1);

    // CPU alone: pointer moves to DMA after each grant but must not block it
    for (int i = 0; i < 3; i++) begin
      r = '{addr: 17'(32'h0A0 + i), wstrb: '0, wdata: '0}; rq_c.push_back(r);
    end
    service();
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("cpu_alone_en", 64'(s_en), 64'(i % 2 == 0));
      chk("cpu_alone_ready", 64'(s_rdy[1]), 64'(i % 2 == 1));
    end

    // reset during the response cycle of a CPU read
    r = '{addr: 17'h00300, wstrb: '0, wdata: '0}; rq_c.push_back(r);
    service();
    cyc();
    chk("mid_rst_grant_en", 64'(s_en), 64'd1);
    chk("mid_rst_grant_addr", 64'(s_addr), 64'h300);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_no_ready", 64'(s_rdy), 64'd0);
    chk("mid_rst_no_en", 64'(s_en), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("mid_rst_release_en", 64'(s_en), 64'd0);
    cyc();
    chk("mid_rst_regrant_en", 64'(s_en), 64'd1);
    chk("mid_rst_regrant_addr", 64'(s_addr), 64'h300);
    cyc();
    chk("mid_rst_ready", 64'(s_rdy), 64'b010);

    chk("scoreboard_empty", 64'(eq_d.size() + eq_c.size() + eq_m.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
